// File: rtl/console_writer_pkg.sv
// Shared types and constants for the console writer and its command FIFO.
package console_pkg;

  localparam int NUM_CELLS_X_DEF = 80;

  localparam logic [7:0] CHAR_NUL   = 8'h00;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_TAB   = 8'h09;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_HOLDOFF  = 2'd2
`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
    ,ST_TAB_FILL = 2'd3
`endif
  } cw_state_t;

  typedef struct packed {
    logic        is_cursor;
    logic [11:0] payload;
  } cw_cmd_t;

endpackage

// File: rtl/console_writer_cmd_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full are ignored.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/console_writer.sv
// Buffers CPU char/cursor writes and replays them to the display driver.
// Optional TAB expansion to spaces with CONSOLE_WRITER_TAB_EXPAND_EN.
module console_writer import console_pkg::*; #(
  parameter int FIFO_DEPTH  = 16,
  parameter int NUM_CELLS_X = NUM_CELLS_X_DEF,
  parameter int TAB_WIDTH   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  DataIn,
  input  logic        DataWE,
  input  logic [11:0] CursorIn,
  input  logic        CursorWE,
  output logic        DsrReady,
  output logic        Idle,
  output logic        Overflow,
  output logic [6:0]  Column,
  output logic        CharWE,
  output logic [7:0]  CharIn,
  output logic        AddressWE,
  output logic [11:0] AddressIn,
  input  logic        Ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [6:0] COL_LAST = 7'(NUM_CELLS_X - 1);

  cw_state_t   r_state, w_state_next;
  cw_cmd_t     w_cmd_in, w_head;
  logic [AW:0] w_count, w_count_next;
  logic        w_full, w_empty, w_push, w_pop;
  logic        w_send_cmd, w_send_space;
  logic        r_dsr_ready, r_overflow, r_char_we, r_addr_we;
  logic [7:0]  r_char_in;
  logic [11:0] r_addr_in;
  logic [6:0]  r_column;

`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
  localparam int TRW = $clog2(TAB_WIDTH + 1);
  logic [TRW-1:0] r_tab_remain;
  logic           w_head_is_tab, w_tab_load;
  assign w_head_is_tab = !w_head.is_cursor && (w_head.payload[7:0] == CHAR_TAB);
`endif

  function automatic logic [6:0] f_next_col(input logic [6:0] col, input logic [7:0] ch);
    case (ch)
      CHAR_LF:  f_next_col = 7'd0;
      CHAR_BS:  f_next_col = (col == 7'd0) ? COL_LAST : col - 7'd1;
      CHAR_NUL: f_next_col = col;
      default:  f_next_col = (col == COL_LAST) ? 7'd0 : col + 7'd1;
    endcase
  endfunction

  // A simultaneous char+cursor write keeps only the cursor command.
  assign w_push = DataWE || CursorWE;
  always_comb begin
    w_cmd_in.is_cursor = CursorWE;
    w_cmd_in.payload   = CursorWE ? CursorIn : {4'h0, DataIn};
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(cw_cmd_t))) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_full) w_count_next = w_count_next + (AW+1)'(1);
    if (w_pop)             w_count_next = w_count_next - (AW+1)'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
          if (w_head_is_tab) w_state_next = ST_TAB_FILL;
          else if (Ready)    w_state_next = ST_STROBE;
`else
          if (Ready) w_state_next = ST_STROBE;
`endif
        end
      end
      ST_STROBE: w_state_next = ST_HOLDOFF;
`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
      ST_HOLDOFF:  w_state_next = (r_tab_remain != '0) ? ST_TAB_FILL : ST_IDLE;
      ST_TAB_FILL: if (Ready) w_state_next = ST_STROBE;
`else
      ST_HOLDOFF:  w_state_next = ST_IDLE;
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_send_cmd   = 1'b0;
    w_send_space = 1'b0;
    w_pop        = 1'b0;
`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
    w_tab_load   = (r_state == ST_IDLE) && !w_empty && w_head_is_tab;
    w_send_cmd   = (r_state == ST_IDLE) && !w_empty && Ready && !w_head_is_tab;
    w_send_space = (r_state == ST_TAB_FILL) && Ready;
    // The TAB entry stays at the head until its final space goes out.
    w_pop        = w_send_cmd || (w_send_space && r_tab_remain == TRW'(1));
`else
    w_send_cmd   = (r_state == ST_IDLE) && !w_empty && Ready;
    w_pop        = w_send_cmd;
`endif
  end

`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             r_tab_remain <= '0;
    else if (w_tab_load)   r_tab_remain <= TRW'(TAB_WIDTH - (int'(r_column) % TAB_WIDTH));
    else if (w_send_space) r_tab_remain <= r_tab_remain - TRW'(1);
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dsr_ready <= 1'b1;
      r_overflow  <= 1'b0;
      r_char_we   <= 1'b0;
      r_char_in   <= '0;
      r_addr_we   <= 1'b0;
      r_addr_in   <= '0;
      r_column    <= '0;
    end else begin
      r_dsr_ready <= (w_count_next != (AW+1)'(FIFO_DEPTH));
      if ((DataWE && CursorWE) || (w_push && w_full)) r_overflow <= 1'b1;
      r_char_we <= 1'b0;
      r_addr_we <= 1'b0;
      if (w_send_cmd) begin
        if (w_head.is_cursor) begin
          r_addr_we <= 1'b1;
          r_addr_in <= w_head.payload;
          r_column  <= 7'(int'(w_head.payload) % NUM_CELLS_X);
        end else begin
          r_char_we <= 1'b1;
          r_char_in <= w_head.payload[7:0];
          r_column  <= f_next_col(r_column, w_head.payload[7:0]);
        end
      end else if (w_send_space) begin
        r_char_we <= 1'b1;
        r_char_in <= CHAR_SPACE;
        r_column  <= f_next_col(r_column, CHAR_SPACE);
      end
    end
  end

  assign DsrReady  = r_dsr_ready;
  assign Overflow  = r_overflow;
  assign CharWE    = r_char_we;
  assign CharIn    = r_char_in;
  assign AddressWE = r_addr_we;
  assign AddressIn = r_addr_in;
  assign Column    = r_column;
  assign Idle      = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: expected commands/columns queued on drive, checked on strobe.
module tb_console_writer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  DataIn;
  logic        DataWE;
  logic [11:0] CursorIn;
  logic        CursorWE;
  logic        DsrReady, Idle, Overflow;
  logic [6:0]  Column;
  logic        CharWE, AddressWE;
  logic [7:0]  CharIn;
  logic [11:0] AddressIn;
  logic        Ready;

  console_writer dut (
    .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .DataWE(DataWE),
    .CursorIn(CursorIn), .CursorWE(CursorWE), .DsrReady(DsrReady), .Idle(Idle),
    .Overflow(Overflow), .Column(Column), .CharWE(CharWE), .CharIn(CharIn),
    .AddressWE(AddressWE), .AddressIn(AddressIn), .Ready(Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [12:0] cmd;
    logic [6:0]  col;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_cyc = -1;
  bit   spacing_on = 0;
  int   m_col = 0;
  int   base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_col(input int col, input logic [7:0] ch);
    if (ch == 8'h0A)      return 0;
    else if (ch == 8'h08) return (col == 0) ? 79 : col - 1;
    else if (ch == 8'h00) return col;
    else                  return (col == 79) ? 0 : col + 1;
  endfunction

  task automatic expect_cmd(input logic cur, input logic [11:0] v);
    exp_t e;
    m_col = cur ? (int'(v) % 80) : model_col(m_col, v[7:0]);
    e.cmd = {cur, v};
    e.col = 7'(m_col);
    sb.push_back(e);
  endtask

  task automatic push_cmd(input logic cur, input logic [11:0] v, input bit accept);
    if (cur) begin CursorWE = 1'b1; CursorIn = v; end
    else     begin DataWE = 1'b1; DataIn = v[7:0]; end
    if (accept) expect_cmd(cur, v);
    @(negedge Clk);
    DataWE = 1'b0;
    CursorWE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    sb.delete();
    m_col = 0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || !Idle) && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    check("drain_done", {31'b0, (sb.size() == 0 && Idle)}, 1);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    cyc++;
    if (!Reset && (CharWE || AddressWE)) begin
      strobe_cnt++;
      check("strobe_excl", {31'b0, CharWE && AddressWE}, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("cmd", {19'b0, AddressWE, (AddressWE ? AddressIn : {4'h0, CharIn})}, {19'b0, e.cmd});
        check("col", {25'b0, Column}, {25'b0, e.col});
      end
      if (spacing_on && last_cyc >= 0) check("spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; DataIn = '0; DataWE = 0; CursorIn = '0; CursorWE = 0; Ready = 1'b1;
    #1;
    check("rst_charwe", {31'b0, CharWE}, 0);
    check("rst_addrwe", {31'b0, AddressWE}, 0);
    check("rst_charin", {24'b0, CharIn}, 0);
    check("rst_addrin", {20'b0, AddressIn}, 0);
    check("rst_ovf", {31'b0, Overflow}, 0);
    check("rst_col", {25'b0, Column}, 0);
    check("rst_dsr", {31'b0, DsrReady}, 1);
    check("rst_idle", {31'b0, Idle}, 1);
    @(negedge Clk);
    Reset = 1'b0;

    // Single char latency: strobe exactly two cycles after the write.
    push_cmd(1'b0, 12'h041, 1'b1);
    check("lat_c1", {31'b0, CharWE}, 0);
    @(negedge Clk);
    check("lat_c2", {31'b0, CharWE}, 1);
    check("lat_c2_data", {24'b0, CharIn}, 32'h41);
    check("lat_c2_col", {25'b0, Column}, 1);
    @(negedge Clk);
    check("lat_c3", {31'b0, CharWE}, 0);
    @(negedge Clk);
    check("lat_c4_idle", {31'b0, Idle}, 1);

    // Fill with Ready low, overflow on the 17th, then drain at full rate.
    do_reset();
    Ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_cmd(1'b0, 12'h041, i < 16);
      if (i == 14) check("dsr_at15", {31'b0, DsrReady}, 1);
      if (i == 15) check("dsr_at16", {31'b0, DsrReady}, 0);
    end
    check("full_ovf", {31'b0, Overflow}, 1);
    check("full_dsr", {31'b0, DsrReady}, 0);
    base = strobe_cnt;
    last_cyc = -1;
    spacing_on = 1;
    Ready = 1'b1;
    wait_drain(200);
    spacing_on = 0;
    check("burst_cnt", strobe_cnt - base, 16);
    check("burst_dsr", {31'b0, DsrReady}, 1);

    // Char and cursor in the same cycle: only the cursor survives.
    do_reset();
    DataWE = 1'b1; DataIn = 8'h41; CursorWE = 1'b1; CursorIn = 12'h0A5;
    expect_cmd(1'b1, 12'h0A5);
    @(negedge Clk);
    DataWE = 1'b0; CursorWE = 1'b0;
    wait_drain(50);
    check("both_col", {25'b0, Column}, 5);
    check("both_ovf", {31'b0, Overflow}, 1);

    // Column edge cases: printable, BS, LF, BS wrap.
    do_reset();
    last_cyc = -1;
    spacing_on = 1;
    push_cmd(1'b0, 12'h041, 1'b1);
    push_cmd(1'b0, 12'h008, 1'b1);
    push_cmd(1'b0, 12'h00A, 1'b1);
    push_cmd(1'b0, 12'h008, 1'b1);
    wait_drain(100);
    spacing_on = 0;
    check("seq_col", {25'b0, Column}, 79);
    check("seq_ovf", {31'b0, Overflow}, 0);

    // Cursor to column 3, then TAB.
    do_reset();
    push_cmd(1'b1, 12'h003, 1'b1);
`ifdef CONSOLE_WRITER_TAB_EXPAND_EN
    push_cmd(1'b0, 12'h009, 1'b0);
    for (int i = 0; i < 5; i++) expect_cmd(1'b0, 12'h020);
    wait_drain(100);
    check("tab_col", {25'b0, Column}, 8);
`else
    push_cmd(1'b0, 12'h009, 1'b1);
    wait_drain(100);
    check("tab_col", {25'b0, Column}, 4);
`endif

    // Asynchronous reset in the middle of a strobe.
    do_reset();
    push_cmd(1'b0, 12'h041, 1'b1);
    push_cmd(1'b0, 12'h042, 1'b1);
    push_cmd(1'b0, 12'h043, 1'b1);
    begin : wait_strobe
      int n = 0;
      while (!CharWE && n < 20) begin
        @(negedge Clk);
        n++;
      end
      check("midrst_saw_strobe", {31'b0, CharWE}, 1);
    end
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_charwe", {31'b0, CharWE}, 0);
    check("midrst_dsr", {31'b0, DsrReady}, 1);
    check("midrst_idle", {31'b0, Idle}, 1);
    check("midrst_col", {25'b0, Column}, 0);
    sb.delete();
    m_col = 0;
    @(negedge Clk);
    Reset = 1'b0;
    base = strobe_cnt;
    repeat (20) @(negedge Clk);
    check("midrst_no_strobes", strobe_cnt - base, 0);
    check("midrst_idle_after", {31'b0, Idle}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- CPU-facing producer for the display driver's character/cursor write interface.
- Buffers character writes and cursor-set commands from the memory-mapped display data/cursor registers in a small FIFO.
- Replays them to the display driver using its Ready handshake: one strobe per command, with a mandatory holdoff cycle.
- Tracks the current cursor column for status and, optionally, TAB expansion.

Parameters:
- FIFO_DEPTH, 16, number of buffered commands; power of two, minimum 2.
- NUM_CELLS_X, 80, screen columns; used for column tracking.
- TAB_WIDTH, 8, tab stop spacing; must divide NUM_CELLS_X.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous reset, active-high.
- DataIn  in  8  character from the CPU display data register.
- DataWE  in  1  one-cycle strobe: enqueue a character command.
- CursorIn  in  12  new cursor cell address (row*NUM_CELLS_X+col).
- CursorWE  in  1  one-cycle strobe: enqueue a cursor-set command.
- DsrReady  out  1  high when the FIFO is not full (CPU status bit).
- Idle  out  1  FIFO empty and FSM in IDLE.
- Overflow  out  1  sticky; set when a command is dropped.
- Column  out  7  tracked cursor column, 0..NUM_CELLS_X-1.
- CharWE  out  1  character strobe to the display driver.
- CharIn  out  8  character to the display driver.
- AddressWE  out  1  cursor-address strobe to the display driver.
- AddressIn  out  12  cursor address to the display driver.
- Ready  in  1  display driver can accept a strobe.

Behaviour:
- Reset (async, any time, including mid-strobe):
  - FIFO emptied; FSM to IDLE.
  - CharWE=0, AddressWE=0, CharIn=0, AddressIn=0.
  - Overflow=0, Column=0, DsrReady=1, Idle=1.
- FIFO entry is {is_cursor(1), payload(12)}. Characters occupy payload[7:0], upper bits 0.
- Enqueue rules:
  - Enqueue happens on the clock edge where the strobe is high.
  - DataWE and CursorWE together: only the cursor command is enqueued; the char is dropped and Overflow is set.
  - Strobe while count==FIFO_DEPTH: dropped, Overflow set, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
- DsrReady = (count != FIFO_DEPTH). It is registered and reflects the count after each edge.
- All driver-side outputs are registered. CharWE and AddressWE are never high together.
- FSM states: IDLE, STROBE, HOLDOFF, plus TAB_FILL when TAB expansion is compiled in.
  - IDLE: if FIFO non-empty and Ready=1, pop the head and register outputs, then go to STROBE. Otherwise stay; strobes stay 0.
  - STROBE: exactly one cycle with CharWE=1 (char) or AddressWE=1 (cursor). Go to HOLDOFF.
  - HOLDOFF: one cycle, strobes 0, so the driver can finish its post-write state. Go to IDLE.
- Latency: DataWE high in cycle k with the FIFO empty and Ready=1 gives CharWE high in cycle k+2.
- Throughput: one command per 3 cycles.
- Ready=0 in IDLE stalls indefinitely with no timeout. Ready is sampled only in IDLE.
- Column update happens on entering STROBE:
  - 0x0A: Column=0.
  - 0x08: Column-1; at 0 it becomes NUM_CELLS_X-1.
  - 0x00: unchanged.
  - Any other char: Column+1; at NUM_CELLS_X-1 it wraps to 0.
  - Cursor command: Column = CursorIn % NUM_CELLS_X, using the dequeued payload.
- Idle = FIFO empty and state==IDLE.

Optional Feature:
- Macro CONSOLE_WRITER_TAB_EXPAND_EN.
- Defined: a head char 0x09 is not sent to the driver.
  - IDLE loads TabRemain = TAB_WIDTH - (Column % TAB_WIDTH), range 1..TAB_WIDTH, then enters TAB_FILL.
  - TAB_FILL sends space 0x20 through the STROBE/HOLDOFF sequence, waiting for Ready before each one, and updates Column.
  - The 0x09 entry is popped only after the last space.
  - Reset mid-expansion discards the remainder.
- Undefined: 0x09 is treated as an ordinary printable char (Column+1). The TAB_FILL state and TabRemain logic are absent.

Decomposition:
- Package console_pkg:
  - cw_state_t enum.
  - cw_cmd_t packed struct {is_cursor, payload[11:0]}.
  - Char constants CHAR_NUL=0x00, CHAR_BS=0x08, CHAR_TAB=0x09, CHAR_LF=0x0A, CHAR_SPACE=0x20.
  - Default NUM_CELLS_X.
- One sub-module, cmd_fifo:
  - Synchronous FIFO parameterised by depth and width.
  - Async active-high reset.
  - Provides count, full and empty; push is ignored when full.

Test Plan:
- Ready=1, DataWE with 0x41 at cycle 0 -> CharWE=1 with CharIn=0x41 in cycle 2 only; Column 0->1; Idle=1 by cycle 4.
- Ready held 0, 17 DataWE writes (FIFO_DEPTH=16) -> DsrReady=0 after the 16th; the 17th is dropped and Overflow=1; after Ready=1, exactly 16 CharWE pulses spaced 3 cycles apart.
- DataWE=0x41 and CursorWE with 0x0A5 (165) in the same cycle -> only AddressWE=1 with AddressIn=0x0A5; Column=5; Overflow=1.
- Sequence 'A', 0x08, 0x0A, 0x08 -> Column 1, 0, 0, 79; driver sees the chars in order with HOLDOFF gaps.
- TAB_EXPAND_EN defined, Column=3, 0x09 -> 5 CharWE pulses with 0x20, Column=8, no 0x09 emitted. Undefined -> one CharWE with 0x09, Column=4.
- Reset asserted asynchronously during STROBE -> CharWE falls immediately, FIFO empty, DsrReady=1; no further strobes after release.
